// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment scan driver with per-frame digit snapshot and anode guard gap.
// Optional: define SEG7_LEAD_ZERO_BLANK_EN to blank a zero in the leftmost slot.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] dig0,
  input  logic [6:0] dig1,
  input  logic [6:0] dig2,
  input  logic [6:0] dig3,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        sl_q, sl_d;
  logic [3:0][6:0]   sh_q, sh_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        an_q, an_d;
  logic              in_guard;
  logic              cnt_wrap;

  function automatic logic [6:0] decode(input logic [6:0] v);
    logic [6:0] s;
    case (v)
      7'd0:    s = 7'h40;
      7'd1:    s = 7'h79;
      7'd2:    s = 7'h24;
      7'd3:    s = 7'h30;
      7'd4:    s = 7'h19;
      7'd5:    s = 7'h12;
      7'd6:    s = 7'h02;
      7'd7:    s = 7'h78;
      7'd8:    s = 7'h00;
      7'd9:    s = 7'h10;
      7'd10:   s = 7'h08;
      7'd11:   s = 7'h03;
      7'd12:   s = 7'h46;
      7'd13:   s = 7'h21;
      7'd14:   s = 7'h06;
      7'd15:   s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // GUARD==0 means no blanking gap at all.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt_q < CW'(GUARD));
    end
  endgenerate

  assign cnt_wrap = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sl_q  <= '0;
      sh_q  <= '0;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      an_q  <= 4'hF;
    end else begin
      cnt_q <= cnt_d;
      sl_q  <= sl_d;
      sh_q  <= sh_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  // Shadows track inputs while disabled; when running they only reload at frame end.
  always_comb begin
    cnt_d = cnt_q;
    sl_d  = sl_q;
    sh_d  = sh_q;
    if (!en) begin
      cnt_d = '0;
      sl_d  = '0;
      sh_d  = {dig3, dig2, dig1, dig0};
    end else begin
      if (cnt_wrap) begin
        cnt_d = '0;
        sl_d  = sl_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_wrap && (sl_q == 2'd3)) begin
        sh_d = {dig3, dig2, dig1, dig0};
      end
    end
  end

  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = 4'hF;
    if (en && !in_guard) begin
      an_d  = ~(4'b1000 >> sl_q);
      seg_d = decode(sh_q[sl_q]);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
      if ((sl_q == 2'd0) && (sh_q[0] == 7'd0)) begin
        seg_d = 7'h7F;
      end
`else
`endif
      dp_d  = (sl_q != 2'd1);
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, GUARD=1, plus a random anode-safety sweep.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam int GUARD    = 1;

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  localparam logic [6:0] Z0 = 7'h7F;
`else
  localparam logic [6:0] Z0 = 7'h40;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] dig0, dig1, dig2, dig3;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int tests_run = 0;
  int tests_failed = 0;

  logic [6:0] exp_q[$];
  logic [3:0] an_tab[4];

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .dig0 (dig0),
    .dig1 (dig1),
    .dig2 (dig2),
    .dig3 (dig3),
    .seg  (seg),
    .dp   (dp),
    .an   (an)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_blank(input string tag);
    check({tag, ".an"}, 32'(an), 32'hF);
    check({tag, ".seg"}, 32'(seg), 32'h7F);
    check({tag, ".dp"}, 32'(dp), 32'h1);
  endtask

  // One slot: guard cycle then SCAN_DIV-GUARD lit cycles; expected segment taken from exp_q.
  task automatic check_slot(input int slot);
    logic [6:0] s;
    s = exp_q.pop_front();
    tick();
    check_blank($sformatf("slot%0d.guard", slot));
    for (int i = 1; i < SCAN_DIV; i++) begin
      tick();
      check($sformatf("slot%0d.an", slot), 32'(an), 32'(an_tab[slot]));
      check($sformatf("slot%0d.seg", slot), 32'(seg), 32'(s));
      check($sformatf("slot%0d.dp", slot), 32'(dp), (slot == 1) ? 32'h0 : 32'h1);
    end
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    exp_q.push_back(s0);
    exp_q.push_back(s1);
    exp_q.push_back(s2);
    exp_q.push_back(s3);
  endtask

  task automatic set_digs(input logic [6:0] d0, input logic [6:0] d1,
                          input logic [6:0] d2, input logic [6:0] d3);
    dig0 = d0;
    dig1 = d1;
    dig2 = d2;
    dig3 = d3;
  endtask

  initial begin
    int m_cnt;
    bit exp_blank;
    an_tab[0] = 4'h7;
    an_tab[1] = 4'hB;
    an_tab[2] = 4'hD;
    an_tab[3] = 4'hE;

    rst = 1'b1;
    en  = 1'b0;
    set_digs(7'd0, 7'd0, 7'd0, 7'd0);
    repeat (3) tick();
    check_blank("reset");

    rst = 1'b0;
    en  = 1'b1;
    set_digs(7'd1, 7'd2, 7'd3, 7'd4);

    // Frame 1 shows the cleared shadows.
    push_frame(Z0, 7'h40, 7'h40, 7'h40);
    for (int k = 0; k < 4; k++) check_slot(k);

    // Frame 2: snapshot 1,2,3,4; dig2 changes while slot 1 is lit.
    push_frame(7'h79, 7'h24, 7'h30, 7'h19);
    check_slot(0);
    tick();
    check_blank("f2.s1.guard");
    tick();
    check("f2.s1.seg", 32'(seg), 32'h24);
    dig2 = 7'd7;
    exp_q.pop_front();
    tick();
    check("f2.s1.seg_b", 32'(seg), 32'h24);
    tick();
    check("f2.s1.dp", 32'(dp), 32'h0);
    check_slot(2);
    check_slot(3);

    // Frame 3 picks up dig2=7; out-of-range and hex digits loaded for frame 4.
    push_frame(7'h79, 7'h24, 7'h78, 7'h19);
    check_slot(0);
    set_digs(7'd20, 7'd2, 7'd7, 7'd10);
    check_slot(1);
    check_slot(2);
    check_slot(3);

    push_frame(7'h7F, 7'h24, 7'h78, 7'h08);
    for (int k = 0; k < 4; k++) check_slot(k);

    // Drop enable while slot 2 is lit.
    push_frame(7'h7F, 7'h24, 7'h78, 7'h08);
    check_slot(0);
    check_slot(1);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    tick();
    check_blank("f5.s2.guard");
    tick();
    check("f5.s2.an", 32'(an), 32'hD);
    check("f5.s2.seg", 32'(seg), 32'h78);
    en = 1'b0;
    tick();
    check_blank("en_drop");
    set_digs(7'd5, 7'd9, 7'd0, 7'd8);
    repeat (2) begin
      tick();
      check_blank("disabled");
    end
    en = 1'b1;
    push_frame(7'h12, 7'h10, 7'h40, 7'h00);
    for (int k = 0; k < 4; k++) check_slot(k);

    // Reset asserted while slot 3 is lit.
    push_frame(7'h12, 7'h10, 7'h40, 7'h00);
    check_slot(0);
    check_slot(1);
    check_slot(2);
    void'(exp_q.pop_front());
    tick();
    check_blank("f7.s3.guard");
    tick();
    check("f7.s3.an", 32'(an), 32'hE);
    check("f7.s3.seg", 32'(seg), 32'h00);
    rst = 1'b1;
    tick();
    check_blank("mid_reset");
    rst = 1'b0;
    push_frame(Z0, 7'h40, 7'h40, 7'h40);
    for (int k = 0; k < 4; k++) check_slot(k);

    // Random sweep: at most one anode low, and all dark during the guard cycles.
    m_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      set_digs(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
               7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
      en = ($urandom_range(0, 7) != 0);
      exp_blank = !en || (m_cnt < GUARD);
      m_cnt = en ? ((m_cnt == SCAN_DIV - 1) ? 0 : m_cnt + 1) : 0;
      tick();
      check("rand.onehot", 32'($countones(~an) <= 1), 32'h1);
      if (exp_blank) begin
        check("rand.guard_an", 32'(an), 32'hF);
        check("rand.guard_dp", 32'(dp), 32'h1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
